// File: rtl/move_stack.sv
// rtl/move_stack.sv - move-history LIFO and write/retract event sequencer for the gobang board
module move_stack #(
    parameter int DEPTH   = 225,
    parameter int CNT_W   = 8,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               place_req,
    input  logic [COORD_W-1:0] place_x,
    input  logic [COORD_W-1:0] place_y,
    input  logic               undo_req,
    input  logic               clr,
    output logic               write,
    output logic               retract,
    output logic               write_color,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [CNT_W-1:0]   move_cnt,
    output logic               empty,
    output logic               full,
    output logic               busy,
    output logic               err
);

    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLACE,
        S_UNDO_RD,
        S_UNDO_OUT
    } state_t;

    state_t               r_state;
    logic [2*COORD_W-1:0] r_mem [DEPTH];
    logic [2*COORD_W-1:0] r_rd_data;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_write;
    logic                 r_retract;
    logic                 r_color;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_busy;
    logic                 r_err;

    logic [CNT_W-1:0]     w_cnt_inc;
    logic [CNT_W-1:0]     w_cnt_dec;
    logic                 w_is_full;
    logic                 w_is_empty;
    logic                 w_idle_req;
    logic                 w_do_place;
    logic                 w_do_undo;

    assign w_cnt_inc  = r_cnt + LP_ONE;
    assign w_cnt_dec  = r_cnt - LP_ONE;
    assign w_is_full  = (r_cnt == LP_DEPTH);
    assign w_is_empty = (r_cnt == '0);
    assign w_idle_req = (r_state == S_IDLE) && rst_n && !clr;
    // undo outranks place; a simultaneous place is dropped
    assign w_do_undo  = w_idle_req && undo_req && !w_is_empty;
    assign w_do_place = w_idle_req && !undo_req && place_req && !w_is_full;

    // history RAM: write on accepted place, synchronous read on accepted undo
    always_ff @(posedge clk) begin
        if (w_do_place) begin
            r_mem[r_cnt] <= {place_x, place_y};
        end
        if (w_do_undo) begin
            r_rd_data <= r_mem[w_cnt_dec];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_retract <= 1'b0;
            r_color   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else if (clr) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_retract <= 1'b0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_write   <= 1'b0;
            r_retract <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (undo_req) begin
                        if (w_is_empty) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= S_UNDO_RD;
                            r_busy  <= 1'b1;
                        end
                    end else if (place_req) begin
                        if (w_is_full) begin
                            r_err <= 1'b1;
                        end else begin
                            // strobe, color and coords are registered on entry to PLACE
                            r_state <= S_PLACE;
                            r_busy  <= 1'b1;
                            r_write <= 1'b1;
                            r_color <= r_cnt[0];
                            r_x     <= place_x;
                            r_y     <= place_y;
                            r_cnt   <= w_cnt_inc;
                            r_empty <= 1'b0;
                            r_full  <= (w_cnt_inc == LP_DEPTH);
                        end
                    end
                end
                S_PLACE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_UNDO_RD: begin
                    r_state   <= S_UNDO_OUT;
                    r_retract <= 1'b1;
                    r_color   <= w_cnt_dec[0];
                    r_x       <= r_rd_data[2*COORD_W-1:COORD_W];
                    r_y       <= r_rd_data[COORD_W-1:0];
                    r_cnt     <= w_cnt_dec;
                    r_empty   <= (w_cnt_dec == '0);
                    r_full    <= 1'b0;
                end
                S_UNDO_OUT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign write       = r_write;
    assign retract     = r_retract;
    assign write_color = r_color;
    assign wr_x        = r_x;
    assign wr_y        = r_y;
    assign move_cnt    = r_cnt;
    assign empty       = r_empty;
    assign full        = r_full;
    assign busy        = r_busy;
    assign err         = r_err;

endmodule

// File: tb/tb_move_stack.sv
// tb/tb_move_stack.sv - scoreboard bench for move_stack
module tb_move_stack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       place_req;
    logic [3:0] place_x;
    logic [3:0] place_y;
    logic       undo_req;
    logic       clr;
    logic       write;
    logic       retract;
    logic       write_color;
    logic [3:0] wr_x;
    logic [3:0] wr_y;
    logic [7:0] move_cnt;
    logic       empty;
    logic       full;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // kind: 0 write, 1 retract, 2 err
    typedef struct {
        logic [1:0] kind;
        logic       color;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] cnt;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] hist[$];

    move_stack #(.DEPTH(225), .CNT_W(8), .COORD_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .place_req(place_req), .place_x(place_x), .place_y(place_y),
        .undo_req(undo_req), .clr(clr),
        .write(write), .retract(retract), .write_color(write_color),
        .wr_x(wr_x), .wr_y(wr_y), .move_cnt(move_cnt),
        .empty(empty), .full(full), .busy(busy), .err(err)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (write || retract || err) begin
            logic [1:0] k;
            ev_t        e;
            k = write ? 2'd0 : (retract ? 2'd1 : 2'd2);
            checks++;
            if ((int'(write) + int'(retract) + int'(err)) != 1) begin
                errors++;
                $display("FAIL strobe_overlap: write=%0b retract=%0b err=%0b, required exactly one", write, retract, err);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: kind=%0d cnt=%0d, required no strobe", k, move_cnt);
            end else begin
                e = sb.pop_front();
                if (k !== e.kind || move_cnt !== e.cnt ||
                    (k != 2'd2 && {write_color, wr_x, wr_y} !== {e.color, e.x, e.y}) ||
                    (k == 2'd2 && busy !== 1'b0)) begin
                    errors++;
                    $display("FAIL strobe_event: got kind=%0d color=%0b x=%0d y=%0d cnt=%0d busy=%0b, required kind=%0d color=%0b x=%0d y=%0d cnt=%0d",
                             k, write_color, wr_x, wr_y, move_cnt, busy, e.kind, e.color, e.x, e.y, e.cnt);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic p, input logic u, input logic c, input logic [3:0] x, input logic [3:0] y);
        place_req = p; undo_req = u; clr = c; place_x = x; place_y = y;
        @(posedge clk);
        #1;
        place_req = 1'b0; undo_req = 1'b0; clr = 1'b0;
    endtask

    task automatic do_place(input logic [3:0] x, input logic [3:0] y);
        ev_t  e;
        int   n;
        n = hist.size();
        if (n == 225) begin
            e = '{kind: 2'd2, color: 1'b0, x: 4'd0, y: 4'd0, cnt: 8'(n)};
        end else begin
            e = '{kind: 2'd0, color: n[0], x: x, y: y, cnt: 8'(n + 1)};
            hist.push_back({x, y});
        end
        sb.push_back(e);
        pulse(1'b1, 1'b0, 1'b0, x, y);
        tick(1);
    endtask

    task automatic expect_undo();
        ev_t        e;
        logic [7:0] c;
        int         n;
        n = hist.size();
        c = hist.pop_back();
        e = '{kind: 2'd1, color: n[0] ^ 1'b1, x: c[7:4], y: c[3:0], cnt: 8'(n - 1)};
        sb.push_back(e);
    endtask

    task automatic do_clr();
        pulse(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        hist.delete();
    endtask

    task automatic test_reset();
        checks++;
        if ({write, retract, write_color, wr_x, wr_y, move_cnt, empty, full, busy, err} !==
            {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: w=%0b r=%0b c=%0b x=%0d y=%0d cnt=%0d e=%0b f=%0b b=%0b err=%0b, required all 0 except empty=1",
                     write, retract, write_color, wr_x, wr_y, move_cnt, empty, full, busy, err);
        end
    endtask

    task automatic test_place();
        sb.push_back('{kind: 2'd0, color: 1'b0, x: 4'd3, y: 4'd4, cnt: 8'd1});
        hist.push_back({4'd3, 4'd4});
        pulse(1'b1, 1'b0, 1'b0, 4'd3, 4'd4);
        checks++;
        if (write !== 1'b1 || busy !== 1'b1 || move_cnt !== 8'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL place_n1: write=%0b busy=%0b cnt=%0d empty=%0b, required 1 1 1 0", write, busy, move_cnt, empty);
        end
        tick(1);
        checks++;
        if (write !== 1'b0 || busy !== 1'b0 || wr_x !== 4'd3 || wr_y !== 4'd4) begin
            errors++;
            $display("FAIL place_n2: write=%0b busy=%0b x=%0d y=%0d, required 0 0 3 4 (coords held)", write, busy, wr_x, wr_y);
        end
    endtask

    task automatic test_undo();
        do_clr();
        do_place(4'd1, 4'd1);
        do_place(4'd2, 4'd2);
        do_place(4'd3, 4'd3);
        expect_undo();
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        checks++;
        if (retract !== 1'b0 || busy !== 1'b1 || move_cnt !== 8'd3) begin
            errors++;
            $display("FAIL undo_n1: retract=%0b busy=%0b cnt=%0d, required 0 1 3", retract, busy, move_cnt);
        end
        tick(1);
        checks++;
        if (retract !== 1'b1 || busy !== 1'b1 || move_cnt !== 8'd2 || wr_x !== 4'd3 || write_color !== 1'b0) begin
            errors++;
            $display("FAIL undo_n2: retract=%0b busy=%0b cnt=%0d x=%0d color=%0b, required 1 1 2 3 0", retract, busy, move_cnt, wr_x, write_color);
        end
        tick(1);
        checks++;
        if (retract !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL undo_n3: retract=%0b busy=%0b, required 0 0", retract, busy);
        end
        expect_undo();
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        tick(2);
        checks++;
        if (move_cnt !== 8'd1 || wr_x !== 4'd2 || wr_y !== 4'd2 || write_color !== 1'b1) begin
            errors++;
            $display("FAIL undo_second: cnt=%0d x=%0d y=%0d color=%0b, required 1 2 2 1", move_cnt, wr_x, wr_y, write_color);
        end
    endtask

    task automatic test_errors();
        do_clr();
        sb.push_back('{kind: 2'd2, color: 1'b0, x: 4'd0, y: 4'd0, cnt: 8'd0});
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        tick(2);
        checks++;
        if (err !== 1'b0 || move_cnt !== 8'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL undo_empty: err=%0b cnt=%0d empty=%0b, required 0 0 1", err, move_cnt, empty);
        end
        for (int i = 0; i < 225; i++) begin
            do_place(4'($urandom_range(14)), 4'($urandom_range(14)));
        end
        checks++;
        if (full !== 1'b1 || move_cnt !== 8'd225 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill: full=%0b cnt=%0d empty=%0b, required 1 225 0", full, move_cnt, empty);
        end
        do_place(4'd5, 4'd5);
        checks++;
        if (full !== 1'b1 || move_cnt !== 8'd225) begin
            errors++;
            $display("FAIL place_full: full=%0b cnt=%0d, required 1 225", full, move_cnt);
        end
        expect_undo();
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        tick(2);
        checks++;
        if (full !== 1'b0 || move_cnt !== 8'd224) begin
            errors++;
            $display("FAIL undo_from_full: full=%0b cnt=%0d, required 0 224", full, move_cnt);
        end
    endtask

    task automatic test_priority();
        do_clr();
        for (int i = 0; i < 5; i++) begin
            do_place(4'(i + 2), 4'(10 - i));
        end
        expect_undo();
        pulse(1'b1, 1'b1, 1'b0, 4'd9, 4'd9);
        tick(2);
        checks++;
        if (move_cnt !== 8'd4) begin
            errors++;
            $display("FAIL undo_over_place: cnt=%0d, required 4", move_cnt);
        end
        sb.push_back('{kind: 2'd0, color: 1'b0, x: 4'd11, y: 4'd12, cnt: 8'd5});
        hist.push_back({4'd11, 4'd12});
        pulse(1'b1, 1'b0, 1'b0, 4'd11, 4'd12);
        pulse(1'b1, 1'b0, 1'b0, 4'd13, 4'd14);
        tick(2);
        checks++;
        if (move_cnt !== 8'd5 || wr_x !== 4'd11 || sb.size() != 0) begin
            errors++;
            $display("FAIL place_while_busy: cnt=%0d x=%0d pending=%0d, required 5 11 0", move_cnt, wr_x, sb.size());
        end
    endtask

    task automatic test_clr_mid();
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        pulse(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        hist.delete();
        checks++;
        if (retract !== 1'b0 || move_cnt !== 8'd0 || empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_undo: retract=%0b cnt=%0d empty=%0b busy=%0b, required 0 0 1 0", retract, move_cnt, empty, busy);
        end
        tick(2);
        do_place(4'd7, 4'd9);
        checks++;
        if (write_color !== 1'b0 || wr_x !== 4'd7 || wr_y !== 4'd9 || move_cnt !== 8'd1) begin
            errors++;
            $display("FAIL place_after_clr: color=%0b x=%0d y=%0d cnt=%0d, required 0 7 9 1", write_color, wr_x, wr_y, move_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 4'd12, 4'd13);
        rst_n = 1'b1;
        hist.delete();
        checks++;
        if ({write, retract, write_color, wr_x, wr_y, move_cnt, empty, full, busy, err} !==
            {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_with_place: w=%0b x=%0d y=%0d cnt=%0d e=%0b b=%0b, required 0 0 0 0 1 0", write, wr_x, wr_y, move_cnt, empty, busy);
        end
        do_place(4'd5, 4'd6);
        pulse(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        hist.delete();
        checks++;
        if (retract !== 1'b0 || move_cnt !== 8'd0 || empty !== 1'b1 || busy !== 1'b0 || wr_x !== 4'd0) begin
            errors++;
            $display("FAIL reset_in_undo: retract=%0b cnt=%0d empty=%0b busy=%0b x=%0d, required 0 0 1 0 0", retract, move_cnt, empty, busy, wr_x);
        end
        tick(3);
    endtask

    initial begin
        rst_n = 1'b0; place_req = 1'b0; undo_req = 1'b0; clr = 1'b0;
        place_x = 4'd0; place_y = 4'd0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        test_reset();
        test_place();
        test_undo();
        test_errors();
        test_priority();
        test_clr_mid();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: pending=%0d, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_stack.md
# move_stack

Move-history LIFO and event sequencer for the gobang board: accepts place and undo requests from the game/input controller, records every placed stone's coordinates, and emits the single-cycle `write`/`retract` strobes, stone color and coordinates consumed by the round counter and the board-memory writer. It is the producing end of the write/retract interface. It derives stone color from move parity, with black first, and on undo replays the popped move's coordinates and color so downstream logic can erase the stone and roll the round count back.

## Interface
Parameters:
- `DEPTH`, 225, maximum stored moves (15x15 board).
- `CNT_W`, 8, width of move counter; must satisfy 2^CNT_W > DEPTH.
- `COORD_W`, 4, width of each board coordinate.

Ports:
- `clk` in 1: system clock (25 MHz).
- `rst_n` in 1: reset, synchronous and active-low.
- `place_req` in 1: one-cycle request to place a stone at `place_x`/`place_y`.
- `place_x`, `place_y` in COORD_W: target coordinates, sampled with `place_req`.
- `undo_req` in 1: one-cycle request to take back the last move.
- `clr` in 1: clear history (board reset).
- `write` out 1: one-cycle strobe, stone placed.
- `retract` out 1: one-cycle strobe, stone removed.
- `write_color` out 1: color of the stone being placed or removed (0 black, 1 white).
- `wr_x`, `wr_y` out COORD_W: coordinates of the stone being placed or removed.
- `move_cnt` out CNT_W: number of stones currently on the board.
- `empty`, `full` out 1: `move_cnt`==0 and `move_cnt`==DEPTH.
- `busy` out 1: high while a request is in progress; new requests are ignored.
- `err` out 1: one-cycle pulse on a rejected request (place when full, undo when empty).

## Operation
- Storage: DEPTH x (2*COORD_W) RAM with synchronous read. Entry i holds move i.
- Color of move i is i[0] (even = black). No color is stored.
- FSM states are IDLE, PLACE, UNDO_RD, UNDO_OUT.
- **IDLE**: priority is `clr` > `undo_req` > `place_req`; a lower-priority simultaneous request is dropped silently.
  - place, not full: write RAM[move_cnt], latch coords, go to PLACE.
  - place, full: pulse `err`, stay in IDLE.
  - undo, not empty: read address move_cnt-1, go to UNDO_RD.
  - undo, empty: pulse `err`, stay in IDLE.
- **PLACE**:
  - `write`=1; `write_color`=old move_cnt[0]; `wr_x`/`wr_y`=latched coords.
  - move_cnt increments.
  - Go to IDLE.
- **UNDO_RD**: wait one cycle for RAM data; go to UNDO_OUT.
- **UNDO_OUT**:
  - `retract`=1; `wr_x`/`wr_y`=RAM data; `write_color`=(move_cnt-1)[0].
  - move_cnt decrements.
  - Go to IDLE.
- **clr** (any state, below reset only): move_cnt=0; FSM to IDLE; `write`/`retract`/`err`=0. Any in-flight strobe is cancelled. RAM contents are not erased.
- `wr_x`, `wr_y` and `write_color` hold their last values between strobes.

## Timing
- Reset values: `write`=0, `retract`=0, `write_color`=0, `wr_x`=0, `wr_y`=0, `move_cnt`=0, `empty`=1, `full`=0, `busy`=0, `err`=0.
- All outputs are registered.
- Place: request at edge N; `write` high during cycle N+1 only; `move_cnt` updated and visible from N+1. `busy` is high in cycle N+1.
- Undo: request at edge N; `retract` high during cycle N+2 only; `move_cnt` updated from N+2. `busy` is high in cycles N+1 and N+2.
- `err`: high during cycle N+1 only; `busy` stays low.
- Back-to-back: a request arriving while `busy`=1 is ignored.
  - Minimum place-to-place spacing is 2 cycles, so `write` is always low for at least 1 cycle between strobes (rising-edge detectable downstream).
  - Minimum spacing is 3 cycles for undo.
- `write_color` and coordinates are valid in the same cycle as the strobe.
- Reset in mid-operation: the pending strobe is never issued.

## Test plan
- Reset then place (3,4): `write` pulses 1 cycle after request, `write_color`=0, `wr_x`=3, `wr_y`=4, `move_cnt`=1, `empty`=0.
- Place (1,1), (2,2), (3,3), then undo twice:
  - first undo: `retract` at N+2 with (3,3), color 0, `move_cnt`=2;
  - second undo: (2,2), color 1, `move_cnt`=1.
- Undo when empty: `err` pulses once, no `retract`, `move_cnt` stays 0. Place when `move_cnt`=225: `err` pulses, no `write`, `full` stays 1.
- `undo_req` and `place_req` in the same cycle with `move_cnt`=5: only `retract` is issued, `move_cnt`=4. `place_req` while `busy`: no extra `write`.
- `clr` asserted in the UNDO_RD cycle: no `retract`; next cycle `move_cnt`=0, `empty`=1. A following place emits color 0 at the new coordinates.
- `rst_n` low for one cycle between a place request and its strobe: `write` is never asserted and all outputs return to their reset values.
